// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data memory arbiter with fixed-latency accesses; MEM_ARBITER_RR_EN selects round-robin tie breaking
module mem_arbiter #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        gnt_d, gnt_d_nxt;
    logic        m_en_nxt, m_we_nxt, i_ack_nxt, d_ack_nxt;
    logic [31:0] m_addr_nxt, m_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
    logic        pick_d;

`ifdef MEM_ARBITER_RR_EN
    // last_i = 1 when fetch won the previous grant; reset value favours fetch on the first tie
    logic last_i, last_i_nxt;

    assign pick_d = d_req && (!i_req || last_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_i <= 1'b0;
        end else begin
            last_i <= last_i_nxt;
        end
    end
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            gnt_d   <= 1'b0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= 32'd0;
            m_wdata <= 32'd0;
            i_rdata <= 32'd0;
            d_rdata <= 32'd0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            gnt_d   <= gnt_d_nxt;
            m_en    <= m_en_nxt;
            m_we    <= m_we_nxt;
            m_addr  <= m_addr_nxt;
            m_wdata <= m_wdata_nxt;
            i_rdata <= i_rdata_nxt;
            d_rdata <= d_rdata_nxt;
            i_ack   <= i_ack_nxt;
            d_ack   <= d_ack_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        gnt_d_nxt   = gnt_d;
        m_en_nxt    = m_en;
        m_we_nxt    = m_we;
        m_addr_nxt  = m_addr;
        m_wdata_nxt = m_wdata;
        i_rdata_nxt = i_rdata;
        d_rdata_nxt = d_rdata;
        i_ack_nxt   = 1'b0;
        d_ack_nxt   = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        last_i_nxt  = last_i;
`endif
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    gnt_d_nxt   = pick_d;
                    m_en_nxt    = 1'b1;
                    m_we_nxt    = pick_d && d_we;
                    m_addr_nxt  = pick_d ? d_addr : i_addr;
                    m_wdata_nxt = pick_d ? d_wdata : 32'd0;
                    cnt_nxt     = WS;
                    state_nxt   = BUSY;
`ifdef MEM_ARBITER_RR_EN
                    last_i_nxt  = !pick_d;
`endif
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    if (gnt_d) begin
                        if (!m_we) begin
                            d_rdata_nxt = m_rdata;
                        end
                        d_ack_nxt = 1'b1;
                    end else begin
                        i_rdata_nxt = m_rdata;
                        i_ack_nxt   = 1'b1;
                    end
                    m_en_nxt  = 1'b0;
                    m_we_nxt  = 1'b0;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
